// File: rtl/fb_pkg.sv
// fb_pkg: shared constants, FSM state type and the iteration-to-colour map
// for the frame-buffer scan-out path.
// Build option: define FB_SCANOUT_PALETTE_EN for the false-colour palette;
// without it the map is greyscale.
package fb_pkg;

  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int V_ACTIVE_DEFAULT = 480;
  localparam int FB_WORDS         = 307200;
  localparam int MAX_ITER         = 127;
  localparam int ADDR_W           = 19;
  localparam int ITER_W           = 7;

  localparam logic [11:0] UNDERFLOW_COLOUR = 12'hF0F;

  typedef enum logic [1:0] {
    WAIT_VB = 2'd0,
    FLUSH   = 2'd1,
    RUN     = 2'd2
  } state_e;

  // Points inside the set are always black; everything else goes through
  // the build-selected ramp.
  function automatic logic [11:0] map_colour(input logic [ITER_W-1:0] i);
    if (i == ITER_W'(MAX_ITER)) begin
      return 12'h000;
    end
`ifdef FB_SCANOUT_PALETTE_EN
    return {i[2:0], 1'b1, i[6:3], ~i[5:2]};
`else
    return {i[6:3], i[6:3], i[6:3]};
`endif
  endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// fb_scanout_if: frame-buffer RAM read port. The scan-out reader is the
// master (drives request and address), the RAM is the slave (returns data
// a fixed number of clocks after each request).
interface fb_scanout_if;
  import fb_pkg::*;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ITER_W-1:0] rd_data;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data
  );

endinterface

// File: rtl/fb_prefetch_fifo.sv
// fb_prefetch_fifo: small first-word-fall-through FIFO holding prefetched
// iteration counts. DEPTH must be a power of two so the pointers wrap on
// their own. flush_i empties it in one clock; storage is never reset.
module fb_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  output logic [W-1:0]           dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // A pop on empty is ignored; a push on full is accepted only if a pop
  // frees the slot in the same clock.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // Data storage: written on accepted pushes only, no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointers and occupancy; push+pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: raster-order frame-buffer reader. Prefetches iteration counts
// into a small FIFO during blanking and pops one per active pixel strobe,
// mapping it to 12-bit RGB. Restarts from address 0 at every vblank entry.
// Build option: FB_SCANOUT_PALETTE_EN selects the palette map in fb_pkg.
module fb_scanout
  import fb_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
  parameter int DEPTH    = 4,
  parameter int RD_LAT   = 1
) (
  input  logic         Clk_100M,
  input  logic         reset,
  fb_scanout_if.master ram,
  input  logic         p_tick,
  input  logic         video_on,
  input  logic [9:0]   pixel_y,
  output logic [11:0]  colour,
  output logic         underflow
);

  localparam int                CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] WORDS = ADDR_W'(H_ACTIVE * V_ACTIVE);

  state_e            state_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] vld_d;
  logic              vb_q;
  logic [11:0]       colour_q;
  logic              underflow_q;

  logic              vblank;
  logic              issue;
  logic              push;
  logic              pop;
  logic              flush;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W:0]    occupancy;
  logic [CNT_W-1:0]  fifo_count;
  logic [ITER_W-1:0] fifo_dout;
  logic              fifo_empty;

  // vblank holds for a whole line; the FSM acts on its first clock only
  // while streaming, so one frame gets exactly one FLUSH.
  assign vblank = !video_on && (pixel_y == 10'(V_ACTIVE));
  assign flush  = (state_q == FLUSH);

  // Reads still in the RAM pipe are counted against FIFO space so that a
  // return can never find the FIFO full.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < RD_LAT; k++) begin
      inflight = inflight + CNT_W'(vld_q[k]);
    end
  end

  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue     = (state_q == RUN) && (occupancy < (CNT_W + 1)'(DEPTH)) &&
                     (rd_addr_q < WORDS);
  assign push      = (state_q == RUN) && vld_q[RD_LAT-1];
  assign pop       = (state_q == RUN) && p_tick && video_on;

  // Valid pipe shifts one stage per clock; its tail marks a RAM return.
  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = issue;
  end

  fb_prefetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ITER_W)
  ) u_fifo (
    .clk     (Clk_100M),
    .rst     (reset),
    .flush_i (flush),
    .push_i  (push),
    .din_i   (ram.rd_data),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  // Scan-out FSM with registered colour, address counter and sticky flag.
  always_ff @(posedge Clk_100M) begin
    if (reset) begin
      state_q     <= WAIT_VB;
      rd_addr_q   <= '0;
      vld_q       <= '0;
      vb_q        <= 1'b0;
      colour_q    <= 12'h000;
      underflow_q <= 1'b0;
    end else begin
      vb_q  <= vblank;
      vld_q <= vld_d;
      case (state_q)
        WAIT_VB: begin
          if (p_tick) begin
            colour_q <= 12'h000;
          end
          if (vblank) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          rd_addr_q <= '0;
          vld_q     <= '0;
          state_q   <= RUN;
          if (p_tick) begin
            colour_q <= 12'h000;
          end
        end
        RUN: begin
          if (issue) begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
          end
          if (p_tick) begin
            if (!video_on) begin
              colour_q <= 12'h000;
            end else if (fifo_empty) begin
              colour_q    <= UNDERFLOW_COLOUR;
              underflow_q <= 1'b1;
            end else begin
              colour_q <= map_colour(fifo_dout);
            end
          end
          if (vblank && !vb_q) begin
            state_q <= FLUSH;
          end
        end
        default: state_q <= WAIT_VB;
      endcase
    end
  end

  assign ram.rd_en   = issue;
  assign ram.rd_addr = rd_addr_q;
  assign colour      = colour_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: scoreboard bench for fb_scanout on a reduced 32x6 raster.
// Honours FB_SCANOUT_PALETTE_EN for the expected colour map.
module tb_fb_scanout;

  localparam int H        = 32;
  localparam int V        = 6;
  localparam int DEPTH    = 4;
  localparam int RD_LAT   = 1;
  localparam int H_TOTAL  = H + 4;
  localparam int VB_LINES = 3;
  localparam int N        = H * V;
  localparam logic [11:0] UF_COL = 12'hF0F;

  logic        Clk_100M = 1'b0;
  logic        reset;
  logic        p_tick;
  logic        video_on;
  logic [9:0]  pixel_y;
  logic [11:0] colour;
  logic        underflow;

  fb_scanout_if bus ();

  fb_scanout #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .DEPTH    (DEPTH),
    .RD_LAT   (RD_LAT)
  ) dut (
    .Clk_100M  (Clk_100M),
    .reset     (reset),
    .ram       (bus),
    .p_tick    (p_tick),
    .video_on  (video_on),
    .pixel_y   (pixel_y),
    .colour    (colour),
    .underflow (underflow)
  );

  always #5 Clk_100M = ~Clk_100M;

  int          vectors = 0;
  int          miscompares = 0;
  int          ram_mode = 0;
  bit          live = 1'b0;
  bit          chk_rd = 1'b0;
  bit          uf_exp = 1'b0;
  int          exp_addr = 0;
  int          reads = 0;
  int          pix = 0;
  logic [11:0] sb[$];

  function automatic logic [6:0] ram_val(input int a);
    if (ram_mode == 1) return (a == 5) ? 7'd127 : 7'd64;
    return 7'(a % 128);
  endfunction

  function automatic logic [11:0] exp_map(input logic [6:0] i);
    int v;
    v = int'(i);
    if (v == 127) return 12'h000;
`ifdef FB_SCANOUT_PALETTE_EN
    return 12'(((v % 8) * 512) + 256 + ((v / 8) * 16) + (15 - ((v / 4) % 16)));
`else
    return 12'((v / 8) * 273);
`endif
  endfunction

  // RAM model, one clock of read latency.
  always @(posedge Clk_100M) begin
    if (bus.rd_en === 1'b1) bus.rd_data <= ram_val(int'(bus.rd_addr));
  end

  // One clock: check the read request presented before the edge, then
  // apply the inputs for that edge and move to the following negedge.
  task automatic cyc(input logic pt, input logic von, input logic [9:0] py, input logic rs);
    if (chk_rd) begin
      vectors++;
      if (bus.rd_en === 1'b1) begin
        if (!live || int'(bus.rd_addr) != exp_addr || exp_addr >= N) begin
          miscompares++;
          $display("FAIL rd_issue: got rd_en=1 rd_addr=%0d (streaming=%0b), want addr %0d below %0d and only while streaming",
                   bus.rd_addr, live, exp_addr, N);
        end
        exp_addr++;
        reads++;
      end else if (bus.rd_en !== 1'b0) begin
        miscompares++;
        $display("FAIL rd_en_known: got rd_en=%b, want 0 or 1", bus.rd_en);
      end
    end
    reset    = rs;
    p_tick   = pt;
    video_on = von;
    pixel_y  = py;
    @(negedge Clk_100M);
  endtask

  task automatic do_reset;
    chk_rd = 1'b0;
    live   = 1'b0;
    uf_exp = 1'b0;
    cyc(1'b0, 1'b0, 10'd0, 1'b1);
    cyc(1'b0, 1'b0, 10'd0, 1'b1);
    reset  = 1'b0;
    chk_rd = 1'b1;
  endtask

  // Full frame: vblank lines first, then active lines. Optional extra active
  // pixels on the last line (starvation) and an optional reset pulse just
  // before active pixel rst_pix.
  task automatic run_frame(input int extra, input int rst_pix, input bit chk_reads);
    logic [11:0] e;
    logic [11:0] got;
    logic [9:0]  py;
    logic        von;
    int          ext;
    for (int l = 0; l < V + VB_LINES; l++) begin
      py = (l < VB_LINES) ? 10'(V + l) : 10'(l - VB_LINES);
      for (int h = 0; h < H_TOTAL; h++) begin
        ext = (py == 10'(V - 1)) ? extra : 0;
        von = (py < 10'(V)) && (h < H + ext);
        if (l == 0 && h == 0) begin
          live = 1'b1; exp_addr = 0; reads = 0; pix = 0;
        end
        if (von && pix == rst_pix) begin
          cyc(1'b0, von, py, 1'b1);
          live   = 1'b0;
          uf_exp = 1'b0;
        end
        e = 12'h000;
        if (von) begin
          if (live) e = (pix < N) ? exp_map(ram_val(pix)) : UF_COL;
          if (live && pix >= N) uf_exp = 1'b1;
          pix++;
        end
        sb.push_back(e);
        cyc(1'b1, von, py, 1'b0);
        got = sb.pop_front();
        vectors += 2;
        if (colour !== got) begin
          miscompares++;
          $display("FAIL pixel_colour line %0d h %0d: got %h, want %h", py, h, colour, got);
        end
        if (underflow !== uf_exp) begin
          miscompares++;
          $display("FAIL underflow_flag line %0d h %0d: got %b, want %b", py, h, underflow, uf_exp);
        end
        for (int k = 0; k < 3; k++) cyc(1'b0, von, py, 1'b0);
      end
    end
    if (chk_reads) begin
      vectors++;
      if (reads != N) begin
        miscompares++;
        $display("FAIL frame_reads: got %0d reads, want %0d", reads, N);
      end
    end
  endtask

  task automatic test_reset;
    do_reset();
    vectors += 5;
    if (colour !== 12'h000) begin miscompares++; $display("FAIL reset_colour: got %h, want 000", colour); end
    if (bus.rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %b, want 0", bus.rd_en); end
    if (bus.rd_addr !== 19'd0) begin miscompares++; $display("FAIL reset_rd_addr: got %0d, want 0", bus.rd_addr); end
    if (underflow !== 1'b0) begin miscompares++; $display("FAIL reset_underflow: got %b, want 0", underflow); end
    if (dut.fifo_count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d, want 0", dut.fifo_count); end
  endtask

  task automatic test_flush_fill;
    ram_mode = 0;
    do_reset();
    live = 1'b1; exp_addr = 0; reads = 0;
    cyc(1'b0, 1'b0, 10'(V), 1'b0);
    vectors++;
    if (bus.rd_en !== 1'b0) begin miscompares++; $display("FAIL flush_rd_en: got %b, want 0", bus.rd_en); end
    for (int k = 0; k < DEPTH; k++) begin
      cyc(1'b0, 1'b0, 10'(V), 1'b0);
      vectors++;
      if (bus.rd_en !== 1'b1 || bus.rd_addr !== 19'(k)) begin
        miscompares++;
        $display("FAIL fill_read %0d: got rd_en=%b addr=%0d, want rd_en=1 addr=%0d", k, bus.rd_en, bus.rd_addr, k);
      end
    end
    cyc(1'b0, 1'b0, 10'(V), 1'b0);
    vectors++;
    if (bus.rd_en !== 1'b0) begin miscompares++; $display("FAIL fill_stop: got rd_en=%b, want 0", bus.rd_en); end
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0, 10'(V), 1'b0);
    vectors += 2;
    if (dut.fifo_count !== 3'(DEPTH)) begin miscompares++; $display("FAIL fill_count: got %0d, want %0d", dut.fifo_count, DEPTH); end
    if (bus.rd_en !== 1'b0) begin miscompares++; $display("FAIL full_idle: got rd_en=%b, want 0", bus.rd_en); end
  endtask

  task automatic test_push_pop_same;
    logic [11:0] e;
    ram_mode = 0;
    do_reset();
    live = 1'b1; exp_addr = 0; reads = 0;
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0, 10'(V), 1'b0);
    vectors += 2;
    if (dut.fifo_count !== 3'(DEPTH - 1)) begin miscompares++; $display("FAIL pp_pre_count: got %0d, want %0d", dut.fifo_count, DEPTH - 1); end
    if (bus.rd_en !== 1'b0) begin miscompares++; $display("FAIL pp_no_read: got rd_en=%b, want 0", bus.rd_en); end
    sb.push_back(exp_map(ram_val(0)));
    cyc(1'b1, 1'b1, 10'd0, 1'b0);
    e = sb.pop_front();
    vectors += 3;
    if (dut.fifo_count !== 3'(DEPTH - 1)) begin miscompares++; $display("FAIL pp_count: got %0d, want %0d", dut.fifo_count, DEPTH - 1); end
    if (colour !== e) begin miscompares++; $display("FAIL pp_colour: got %h, want %h", colour, e); end
    if (bus.rd_en !== 1'b1 || bus.rd_addr !== 19'(DEPTH)) begin
      miscompares++;
      $display("FAIL pp_resume: got rd_en=%b addr=%0d, want rd_en=1 addr=%0d", bus.rd_en, bus.rd_addr, DEPTH);
    end
  endtask

  task automatic test_stream_frame;
    ram_mode = 0;
    do_reset();
    run_frame(0, -1, 1'b1);
    run_frame(0, -1, 1'b1);
  endtask

  task automatic test_greyscale_pattern;
    ram_mode = 1;
    run_frame(0, -1, 1'b1);
  endtask

  task automatic test_underflow;
    ram_mode = 0;
    run_frame(3, -1, 1'b1);
    run_frame(0, -1, 1'b1);
    vectors++;
    if (underflow !== 1'b1) begin miscompares++; $display("FAIL uf_sticky: got %b, want 1", underflow); end
    do_reset();
    vectors++;
    if (underflow !== 1'b0) begin miscompares++; $display("FAIL uf_cleared: got %b, want 0", underflow); end
  endtask

  task automatic test_reset_midframe;
    ram_mode = 0;
    run_frame(0, 3 * H + 10, 1'b0);
    run_frame(0, -1, 1'b1);
  endtask

  initial begin
    reset    = 1'b1;
    p_tick   = 1'b0;
    video_on = 1'b0;
    pixel_y  = 10'd0;
    test_reset();
    test_flush_fill();
    test_push_pop_same();
    test_stream_frame();
    test_greyscale_pattern();
    test_underflow();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
